// File: rtl/deadband_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | deadband_pkg                                                               |
// | Shared defaults, FSM state encoding and round-robin pick for deadband_sched|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package deadband_pkg;

  localparam int DEF_NCH = 4;
  localparam int DEF_W   = 8;
  localparam int DEF_CHW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CMP   = 2'd2,
    S_EMIT  = 2'd3
  } state_t;

  // First set bit of valid at or above ptr, wrapping modulo n (n a power of 2, <= 32).
  // Offsets are scanned from the far end so the nearest one is written last and wins.
  function automatic int rr_pick(input logic [31:0] valid, input int ptr, input int n);
    int pick;
    int off;
    int idx;
    pick = ptr;
    for (int i = 0; i < 32; i++) begin
      off = 31 - i;
      if (off < n) begin
        idx = (ptr + off) & (n - 1);
        if (valid[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/deadband_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | deadband_if                                                                |
// | Requester sample bus and change-event output bus of deadband_sched         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface deadband_if #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CHW = 2
);
  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic             evt_valid;
  logic [CHW-1:0]   evt_ch;
  logic [W-1:0]     evt_data;
  logic             evt_ready;

  modport slave (
    input  req_valid, req_data, evt_ready,
    output req_ready, evt_valid, evt_ch, evt_data
  );

  modport master (
    output req_valid, req_data, evt_ready,
    input  req_ready, evt_valid, evt_ch, evt_data
  );
endinterface
`default_nettype wire

// File: rtl/deadband_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | deadband_cmp                                                               |
// | Unsigned absolute difference with strict-greater threshold test            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module deadband_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] thr,
  output logic [W-1:0] diff,
  output logic         changed
);

  // Subtract the smaller from the larger so the result always fits in W bits.
  assign diff    = (a > b) ? (a - b) : (b - a);
  assign changed = (diff > thr);

endmodule
`default_nettype wire

// File: rtl/deadband_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | deadband_sched                                                             |
// | Round-robin shared deadband compare over NCH last-reported value slots     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module deadband_sched
  import deadband_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W,
  parameter int CHW = DEF_CHW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [W-1:0] cfg_thresh,
  output logic         busy,
  deadband_if.slave    bus
);

  state_t         r_state;
  logic [CHW-1:0] r_rr_ptr;
  logic [CHW-1:0] r_ch;
  logic [W-1:0]   r_sample;
  logic [W-1:0]   r_thr;
  logic [W-1:0]   r_last [NCH];
  logic           r_evt_valid;
  logic [CHW-1:0] r_evt_ch;
  logic [W-1:0]   r_evt_data;

  logic [CHW-1:0] w_pick;
  logic           w_any;
  logic [W-1:0]   w_sel_data;
  logic [NCH-1:0] w_req_ready;
  logic [W-1:0]   w_unused_diff;
  logic           w_changed;

  assign w_any      = |bus.req_valid;
  assign w_pick     = CHW'(rr_pick(32'(bus.req_valid), 32'(r_rr_ptr), NCH));
  assign w_sel_data = bus.req_data[r_ch*W +: W];

  deadband_cmp #(.W(W)) u_cmp (
    .a       (r_sample),
    .b       (r_last[r_ch]),
    .thr     (r_thr),
    .diff    (w_unused_diff),
    .changed (w_changed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_ch        <= '0;
      r_sample    <= '0;
      r_thr       <= '0;
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_evt_data  <= '0;
      for (int i = 0; i < NCH; i++) r_last[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ena && w_any) begin
            r_ch    <= w_pick;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // A requester that withdrew before acceptance forfeits its turn without moving the pointer.
          if (bus.req_valid[r_ch]) begin
            r_sample <= w_sel_data;
            r_thr    <= cfg_thresh;
            r_rr_ptr <= r_ch + 1'b1;
            r_state  <= S_CMP;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_CMP: begin
          if (w_changed) begin
            r_last[r_ch] <= r_sample;
            r_evt_ch     <= r_ch;
            r_evt_data   <= r_sample;
            r_evt_valid  <= 1'b1;
            r_state      <= S_EMIT;
          end else begin
            r_state      <= S_IDLE;
          end
        end
        S_EMIT: begin
          if (bus.evt_ready) begin
            r_evt_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (r_state == S_GRANT) w_req_ready[r_ch] = 1'b1;
  end

  assign bus.req_ready = w_req_ready;
  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_ch    = r_evt_ch;
  assign bus.evt_data  = r_evt_data;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_deadband_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_deadband_sched                                                          |
// | Directed vector table plus arbitration, back-pressure and reset sequences  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_deadband_sched;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CHW = 2;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic [7:0] thr;
    logic       exp_evt;
    logic [7:0] exp_data;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ena = 1'b0;
  logic [W-1:0] cfg_thresh = '0;
  logic         busy;

  int n_pass  = 0;
  int n_total = 0;

  deadband_if #(.NCH(NCH), .W(W), .CHW(CHW)) bus ();

  deadband_sched #(.NCH(NCH), .W(W), .CHW(CHW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg_thresh (cfg_thresh),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic drive(input int ch, input logic [7:0] data, input logic on);
    bus.req_valid[ch]          = on;
    bus.req_data[ch*W +: W]    = data;
  endtask

  task automatic wait_grant(input int ch, input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
    end
    check(name, 32'(bus.req_ready), 32'(1 << ch));
  endtask

  task automatic wait_evt(input string name);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.evt_valid) break;
    end
    check(name, 32'(bus.evt_valid), 32'd1);
  endtask

  // One sample from one requester with evt_ready held high.
  task automatic do_sample(input vec_t v, input string tag);
    @(posedge clk); #1;
    cfg_thresh = v.thr;
    drive(v.ch, v.data, 1'b1);
    wait_grant(v.ch, {tag, "_grant"});
    @(posedge clk); #1;
    drive(v.ch, v.data, 1'b0);
    cfg_thresh = ~v.thr;
    @(negedge clk);
    check({tag, "_cmp_evt"}, 32'(bus.evt_valid), 32'd0);
    check({tag, "_cmp_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'(v.exp_evt));
    if (v.exp_evt) begin
      check({tag, "_evt_ch"}, 32'(bus.evt_ch), 32'(v.ch));
      check({tag, "_evt_data"}, 32'(bus.evt_data), 32'(v.exp_data));
    end
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, bus.evt_valid}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t       vecs [10];
  vec_t       v;
  logic [7:0] fdata [4];
  int         grants;
  int         evts;

  initial begin
    vecs[0] = '{ch: 0, data: 8'h05, thr: 8'h02, exp_evt: 1'b1, exp_data: 8'h05};
    vecs[1] = '{ch: 0, data: 8'h07, thr: 8'h02, exp_evt: 1'b0, exp_data: 8'h00};
    vecs[2] = '{ch: 0, data: 8'h08, thr: 8'h02, exp_evt: 1'b1, exp_data: 8'h08};
    vecs[3] = '{ch: 2, data: 8'hFF, thr: 8'hFE, exp_evt: 1'b1, exp_data: 8'hFF};
    vecs[4] = '{ch: 2, data: 8'h01, thr: 8'hFE, exp_evt: 1'b0, exp_data: 8'h00};
    vecs[5] = '{ch: 1, data: 8'h00, thr: 8'h00, exp_evt: 1'b0, exp_data: 8'h00};
    vecs[6] = '{ch: 1, data: 8'h01, thr: 8'h00, exp_evt: 1'b1, exp_data: 8'h01};
    vecs[7] = '{ch: 3, data: 8'h80, thr: 8'h7F, exp_evt: 1'b1, exp_data: 8'h80};
    vecs[8] = '{ch: 3, data: 8'h00, thr: 8'h80, exp_evt: 1'b0, exp_data: 8'h00};
    vecs[9] = '{ch: 0, data: 8'h03, thr: 8'h04, exp_evt: 1'b1, exp_data: 8'h03};
    fdata   = '{8'h11, 8'h22, 8'h33, 8'h44};

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.evt_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_evt_ch",    32'(bus.evt_ch),    32'd0);
    check("rst_evt_data",  32'(bus.evt_data),  32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ena   = 1'b1;

    for (int i = 0; i < 10; i++) do_sample(vecs[i], $sformatf("v%0d", i));

    // ena low holds off grants; raising it lets the waiting request through
    @(posedge clk); #1;
    ena        = 1'b0;
    cfg_thresh = 8'hFF;
    drive(1, 8'hAB, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("ena_off_%0d", k), {27'd0, busy, bus.req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    wait_grant(1, "ena_on_grant");
    @(posedge clk); #1;
    drive(1, 8'hAB, 1'b0);
    repeat (3) @(negedge clk);

    // all four requesters held valid: strict rotation, one event each on first pass
    pulse_reset();
    cfg_thresh = 8'h00;
    for (int c = 0; c < NCH; c++) drive(c, fdata[c], 1'b1);
    grants = 0;
    evts   = 0;
    for (int k = 0; k < 100 && grants < 8; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        check($sformatf("rr_grant%0d", grants), 32'(bus.req_ready), 32'(1 << (grants % NCH)));
        grants++;
      end
      if (bus.evt_valid && bus.evt_ready) begin
        check($sformatf("rr_evt%0d_data", evts), 32'(bus.evt_data), 32'(fdata[bus.evt_ch]));
        evts++;
      end
    end
    check("rr_grant_count", 32'(grants), 32'd8);
    check("rr_evt_count",   32'(evts),   32'd4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    check("rr_settled", {30'd0, busy, bus.evt_valid}, 32'd0);

    // stalled consumer: event held stable, no new grant until handshake
    @(posedge clk); #1;
    bus.evt_ready = 1'b0;
    cfg_thresh    = 8'h00;
    drive(1, 8'h55, 1'b1);
    wait_grant(1, "bp_grant");
    @(posedge clk); #1;
    drive(1, 8'h55, 1'b0);
    drive(3, 8'h66, 1'b1);
    wait_evt("bp_evt_up");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold_valid%0d", k), 32'(bus.evt_valid), 32'd1);
      check($sformatf("bp_hold_ch%0d", k),    32'(bus.evt_ch),    32'd1);
      check($sformatf("bp_hold_data%0d", k),  32'(bus.evt_data),  32'h55);
      check($sformatf("bp_hold_ready%0d", k), 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.evt_ready = 1'b1;
    @(negedge clk);
    check("bp_last_valid", 32'(bus.evt_valid), 32'd1);
    wait_grant(3, "bp_resume_grant");
    check("bp_evt_dropped", 32'(bus.evt_valid), 32'd0);
    @(posedge clk); #1;
    drive(3, 8'h66, 1'b0);
    repeat (4) @(negedge clk);

    // asynchronous reset while an event is pending
    @(posedge clk); #1;
    bus.evt_ready = 1'b0;
    cfg_thresh    = 8'h00;
    drive(2, 8'h77, 1'b1);
    wait_grant(2, "ar_grant");
    @(posedge clk); #1;
    drive(2, 8'h77, 1'b0);
    wait_evt("ar_evt_up");
    #2 rst_n = 1'b0;
    #1;
    check("ar_evt_valid", 32'(bus.evt_valid), 32'd0);
    check("ar_busy",      32'(busy),          32'd0);
    check("ar_evt_data",  32'(bus.evt_data),  32'd0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.evt_ready = 1'b1;
    v = '{ch: 2, data: 8'h77, thr: 8'h00, exp_evt: 1'b1, exp_data: 8'h77};
    do_sample(v, "ar_resend");
    v = '{ch: 0, data: 8'h00, thr: 8'h00, exp_evt: 1'b0, exp_data: 8'h00};
    do_sample(v, "ar_slot0_cleared");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
